// File: rtl/rdyack_rr_arbiter_pkg.sv
// Shared types and the rotating priority search used by the rdy/ack arbiters.
// Widths here are upper bounds; instantiations use at most MAX_N sources.
package rdyack_rr_arbiter_pkg;

    localparam int unsigned MAX_N = 32;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned CNT_W = 8;

    typedef struct packed {
        logic [IDX_W-1:0] last;
        logic [CNT_W-1:0] cnt;
    } arb_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req[0..n-1], scanning upward from start and wrapping at n.
    function automatic pick_t rot_prio_pick(input logic [MAX_N-1:0] req,
                                            input int unsigned      n,
                                            input int unsigned      start);
        pick_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                j = (start + k) % n;
                if (!r.found && req[j[IDX_W-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = j[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rdyack_rr_arbiter_pick.sv
// Combinational rotating priority picker: first requester at or after i_start.
module rr_prio_pick
    import rdyack_rr_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_found,
    output logic [IW-1:0]    o_idx
);

    pick_t w_pick;

    always_comb begin
        w_pick = rot_prio_pick(MAX_N'(i_req), N, 32'(i_start));
    end

    assign o_found = w_pick.found;
    assign o_idx   = IW'(w_pick.idx);

endmodule

// File: rtl/rdyack_rr_arbiter.sv
// Round-robin arbiter for N rdy/ack sources onto one registered rdy/ack output,
// with an optional burst lock and load controls for an external data mux/register.
module rdyack_rr_arbiter
    import rdyack_rr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int BURST = 1,
    parameter int IW    = $clog2(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  src_rdys,
    output logic [N-1:0]  src_acks,
    input  logic [N-1:0]  i_mask,
    output logic          dst_rdy,
    input  logic          dst_ack,
    output logic          o_load_en,
    output logic [IW-1:0] o_load_sel,
    output logic [IW-1:0] o_sel
);

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N-1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST-1);
    localparam int               WAIT_LIM = N * BURST;
    localparam int               WAIT_W   = $clog2(WAIT_LIM + 2);

    arb_state_t       r_state;
    logic [N-1:0]     w_req;
    logic [N-1:0]     w_last_oh;
    logic [IDX_W-1:0] w_rr_start;
    logic             w_lock_found;
    logic             w_rr_found;
    logic             w_lock;
    logic             w_found;
    logic             w_can_load;
    logic             w_same;
    logic [IW-1:0]    w_lock_idx;
    logic [IW-1:0]    w_rr_idx;
    logic [IW-1:0]    w_win;

    assign w_req      = src_rdys & ~i_mask;
    assign w_last_oh  = N'(1) << r_state.last;
    assign w_rr_start = (r_state.last == LAST_RST) ? '0 : r_state.last + 1'b1;

    // Lock path only sees the previous winner; it reports whether that source is still eligible.
    rr_prio_pick #(.N(N), .IW(IW)) u_lock_pick (
        .i_req   (w_req & w_last_oh),
        .i_start (r_state.last),
        .o_found (w_lock_found),
        .o_idx   (w_lock_idx)
    );

    rr_prio_pick #(.N(N), .IW(IW)) u_rr_pick (
        .i_req   (w_req),
        .i_start (w_rr_start),
        .o_found (w_rr_found),
        .o_idx   (w_rr_idx)
    );

    // cnt never exceeds CNT_MAX, so inequality is the "below limit" test; BURST=1 never locks.
    assign w_lock     = w_lock_found && (r_state.cnt != CNT_MAX);
    assign w_found    = w_lock || w_rr_found;
    assign w_win      = w_lock ? w_lock_idx : w_rr_idx;
    assign w_can_load = !dst_rdy || dst_ack;
    assign w_same     = (IDX_W'(w_win) == r_state.last);

    assign o_load_en  = w_can_load && w_found;
    assign o_load_sel = w_win;
    assign src_acks   = o_load_en ? (N'(1) << w_win) : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state.last <= LAST_RST;
            r_state.cnt  <= '0;
            dst_rdy      <= 1'b0;
            o_sel        <= '0;
        end else begin
            dst_rdy <= o_load_en || (dst_rdy && !dst_ack);
            if (o_load_en) begin
                r_state.last <= IDX_W'(w_win);
                if (!w_same)
                    r_state.cnt <= '0;
                else if (r_state.cnt != CNT_MAX)
                    r_state.cnt <= r_state.cnt + 1'b1;
                o_sel <= w_win;
            end
        end
    end

    // Grants handed to other sources while each eligible source waits.
    logic [N-1:0][WAIT_W-1:0] r_wait;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_wait <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!w_req[i] || src_acks[i])
                    r_wait[i] <= '0;
                else if (o_load_en && (r_wait[i] != WAIT_W'(WAIT_LIM + 1)))
                    r_wait[i] <= r_wait[i] + 1'b1;
            end
        end
    end

    always @(posedge i_clk) begin
        if (i_rst) begin
            a_acks_onehot: assert ($onehot0(src_acks));
            for (int i = 0; i < N; i++) begin
                a_no_starve: assert (r_wait[i] < WAIT_W'(WAIT_LIM));
            end
        end
    end

    a_out_stable: assert property (@(posedge i_clk) disable iff (!i_rst)
        (dst_rdy && !dst_ack) |=> (dst_rdy && $stable(o_sel)));

endmodule

// File: tb/tb_rdyack_rr_arbiter.sv
// Scoreboard bench: stimulus queues expected grant/output indices, per-instance monitors pop and compare.
module tb_rdyack_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Instance A: N=4 BURST=1
    logic [3:0] rdys_a, mask_a, acks_a;
    logic       dst_rdy_a, dst_ack_a, load_en_a;
    logic [1:0] load_sel_a, sel_a;
    // Instance B: N=4 BURST=3
    logic [3:0] rdys_b, mask_b, acks_b;
    logic       dst_rdy_b, dst_ack_b, load_en_b;
    logic [1:0] load_sel_b, sel_b;
    // Instance C: N=3 BURST=1
    logic [2:0] rdys_c, mask_c, acks_c;
    logic       dst_rdy_c, dst_ack_c, load_en_c;
    logic [1:0] load_sel_c, sel_c;

    rdyack_rr_arbiter #(.N(4), .BURST(1)) u_dut_a (
        .i_clk(clk), .i_rst(rst_n), .src_rdys(rdys_a), .src_acks(acks_a), .i_mask(mask_a),
        .dst_rdy(dst_rdy_a), .dst_ack(dst_ack_a), .o_load_en(load_en_a),
        .o_load_sel(load_sel_a), .o_sel(sel_a)
    );

    rdyack_rr_arbiter #(.N(4), .BURST(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst_n), .src_rdys(rdys_b), .src_acks(acks_b), .i_mask(mask_b),
        .dst_rdy(dst_rdy_b), .dst_ack(dst_ack_b), .o_load_en(load_en_b),
        .o_load_sel(load_sel_b), .o_sel(sel_b)
    );

    rdyack_rr_arbiter #(.N(3), .BURST(1)) u_dut_c (
        .i_clk(clk), .i_rst(rst_n), .src_rdys(rdys_c), .src_acks(acks_c), .i_mask(mask_c),
        .dst_rdy(dst_rdy_c), .dst_ack(dst_ack_c), .o_load_en(load_en_c),
        .o_load_sel(load_sel_c), .o_sel(sel_c)
    );

    int expg_a[$], expo_a[$], expg_b[$], expo_b[$], expg_c[$], expo_c[$];
    int g_a, o_a, g_b, o_b, g_c, o_c;

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_en_a) begin
                if (expg_a.size() == 0) chk("A_extra_grant", int'(load_sel_a), -1);
                else begin
                    g_a = expg_a.pop_front();
                    chk("A_grant_sel", int'(load_sel_a), g_a);
                    chk("A_grant_acks", int'(acks_a), 1 << g_a);
                end
            end
            if (dst_rdy_a && dst_ack_a) begin
                if (expo_a.size() == 0) chk("A_extra_out", int'(sel_a), -1);
                else begin
                    o_a = expo_a.pop_front();
                    chk("A_out_sel", int'(sel_a), o_a);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_en_b) begin
                if (expg_b.size() == 0) chk("B_extra_grant", int'(load_sel_b), -1);
                else begin
                    g_b = expg_b.pop_front();
                    chk("B_grant_sel", int'(load_sel_b), g_b);
                    chk("B_grant_acks", int'(acks_b), 1 << g_b);
                end
            end
            if (dst_rdy_b && dst_ack_b) begin
                if (expo_b.size() == 0) chk("B_extra_out", int'(sel_b), -1);
                else begin
                    o_b = expo_b.pop_front();
                    chk("B_out_sel", int'(sel_b), o_b);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_en_c) begin
                chk("C_sel_range", int'(load_sel_c < 2'd3), 1);
                if (expg_c.size() == 0) chk("C_extra_grant", int'(load_sel_c), -1);
                else begin
                    g_c = expg_c.pop_front();
                    chk("C_grant_sel", int'(load_sel_c), g_c);
                    chk("C_grant_acks", int'(acks_c), 1 << g_c);
                end
            end
            if (dst_rdy_c && dst_ack_c) begin
                if (expo_c.size() == 0) chk("C_extra_out", int'(sel_c), -1);
                else begin
                    o_c = expo_c.pop_front();
                    chk("C_out_sel", int'(sel_c), o_c);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int pat1[5] = '{0, 1, 2, 3, 0};
    int pat3[6] = '{1, 1, 3, 3, 3, 1};
    int pat5[4] = '{1, 2, 0, 1};

    initial begin
        rst_n  = 1'b0;
        rdys_a = '0; mask_a = '0; dst_ack_a = 1'b0;
        rdys_b = '0; mask_b = '0; dst_ack_b = 1'b0;
        rdys_c = '0; mask_c = '0; dst_ack_c = 1'b0;
        #12;
        chk("rst_A_dst_rdy", int'(dst_rdy_a), 0);
        chk("rst_A_o_sel", int'(sel_a), 0);
        chk("rst_A_acks", int'(acks_a), 0);
        chk("rst_B_dst_rdy", int'(dst_rdy_b), 0);
        chk("rst_C_dst_rdy", int'(dst_rdy_c), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // Pure round robin, all requesting, downstream always accepting
        dst_ack_a = 1'b1;
        rdys_a    = 4'b1111;
        foreach (pat1[i]) begin
            expg_a.push_back(pat1[i]);
            expo_a.push_back(pat1[i]);
        end
        repeat (5) cyc();
        rdys_a = '0;
        cyc();
        chk("A_idle_dst_rdy", int'(dst_rdy_a), 0);

        // Single requester against a stalled output
        dst_ack_a = 1'b0;
        rdys_a    = 4'b0100;
        expg_a.push_back(2);
        expo_a.push_back(2);
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            chk("A_hold_dst_rdy", int'(dst_rdy_a), 1);
            chk("A_hold_acks", int'(acks_a), 0);
            chk("A_hold_o_sel", int'(sel_a), 2);
        end
        cyc();
        dst_ack_a = 1'b1;
        expg_a.push_back(2);
        expo_a.push_back(2);
        @(negedge clk);
        chk("A_ack_with_dst_ack", int'(acks_a), 4);
        cyc();
        rdys_a = '0;
        cyc();
        cyc();

        // Burst of three alternating between sources 1 and 3
        dst_ack_b = 1'b1;
        rdys_b    = 4'b0010;
        expg_b.push_back(1);
        expo_b.push_back(1);
        cyc();
        rdys_b = 4'b1010;
        foreach (pat3[i]) begin
            expg_b.push_back(pat3[i]);
            expo_b.push_back(pat3[i]);
        end
        repeat (6) cyc();
        rdys_b = '0;
        cyc();
        cyc();

        // Masking the locked source mid-burst
        rdys_b = 4'b1010;
        expg_b.push_back(1);
        expo_b.push_back(1);
        cyc();
        mask_b = 4'b0010;
        repeat (4) begin
            expg_b.push_back(3);
            expo_b.push_back(3);
        end
        repeat (4) cyc();
        rdys_b = '0;
        mask_b = '0;
        cyc();
        cyc();

        // Non-power-of-2 wrap
        dst_ack_c = 1'b1;
        rdys_c    = 3'b001;
        expg_c.push_back(0);
        expo_c.push_back(0);
        cyc();
        rdys_c = 3'b111;
        foreach (pat5[i]) begin
            expg_c.push_back(pat5[i]);
            expo_c.push_back(pat5[i]);
        end
        repeat (4) cyc();
        rdys_c = '0;
        cyc();
        cyc();

        // Asynchronous reset while the output stage holds source 2
        dst_ack_a = 1'b0;
        rdys_a    = 4'b0100;
        expg_a.push_back(2);
        cyc();
        rdys_a = '0;
        #2;
        chk("A_pre_rst_dst_rdy", int'(dst_rdy_a), 1);
        chk("A_pre_rst_o_sel", int'(sel_a), 2);
        rst_n = 1'b0;
        #1;
        chk("A_async_rst_dst_rdy", int'(dst_rdy_a), 0);
        chk("A_async_rst_o_sel", int'(sel_a), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        rdys_a    = 4'b1111;
        dst_ack_a = 1'b1;
        expg_a.push_back(0); expo_a.push_back(0);
        expg_a.push_back(1); expo_a.push_back(1);
        repeat (2) cyc();
        rdys_a = '0;
        repeat (3) cyc();

        chk("A_grants_pending", expg_a.size(), 0);
        chk("A_outs_pending", expo_a.size(), 0);
        chk("B_grants_pending", expg_b.size(), 0);
        chk("B_outs_pending", expo_b.size(), 0);
        chk("C_grants_pending", expg_c.size(), 0);
        chk("C_outs_pending", expo_c.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
